btb_update_queue: RTL and testbench

- Parametrised successor to the single-entry BTB update holder.
- Buffers up to DEPTH pending BTB writes (pc tag, set, target) between branch resolution and the BTB write port.
- Coalesces repeat updates to the same tag and set, and drains through a valid/ready handshake.
- Provides a combinational lookup port so fetch can forward a target that has not yet been written to the BTB.

---
 rtl/btb_update_queue.sv | 115 +++++++++++
 tb/tb_btb_update_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of pending BTB writes between branch resolution and the BTB write port.
// Fetch can read a queued target combinationally through the lookup port before the BTB is written.
module btb_update_queue #(
  parameter int TAG_WIDTH  = 10,
  parameter int SET_WIDTH  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         enq_valid,
  input  logic [TAG_WIDTH-1:0]         enq_tag,
  input  logic [SET_WIDTH-1:0]         enq_set,
  input  logic [ADDR_WIDTH-1:0]        enq_target,
  output logic                         enq_ready,
  output logic                         deq_valid,
  output logic [TAG_WIDTH-1:0]         deq_tag,
  output logic [SET_WIDTH-1:0]         deq_set,
  output logic [ADDR_WIDTH-1:0]        deq_target,
  input  logic                         deq_ready,
  input  logic [TAG_WIDTH-1:0]         lk_tag,
  input  logic [SET_WIDTH-1:0]         lk_set,
  output logic                         lk_hit,
  output logic [ADDR_WIDTH-1:0]        lk_target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tag_q    [DEPTH];
  logic [SET_WIDTH-1:0]  set_q    [DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [DEPTH];
  logic [PTR_W-1:0]      head, tail;

  logic [DEPTH-1:0] match_vec;
  logic [PTR_W-1:0] match_idx;
  logic             match, enq_fire, deq_fire, coalesce, alloc;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    match_vec = '0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag_q[i] == enq_tag && set_q[i] == enq_set) begin
        match_vec[i] = 1'b1;
        match_idx    = PTR_W'(i);
      end
    end
  end

  assign match     = enq_valid && (|match_vec);
  assign enq_ready = (count < FULL_CNT) || match;
  assign deq_valid = valid[head];
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign deq_fire  = deq_valid && deq_ready && !flush;
  // A hit on the head that is leaving this cycle must re-allocate, or the new target would leave with it.
  assign coalesce  = enq_fire && match && !(deq_fire && match_idx == head);
  assign alloc     = enq_fire && !coalesce;

  assign deq_tag    = deq_valid ? tag_q[head]    : '0;
  assign deq_set    = deq_valid ? set_q[head]    : '0;
  assign deq_target = deq_valid ? target_q[head] : '0;

  always_comb begin
    lk_hit    = 1'b0;
    lk_target = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag_q[i] == lk_tag && set_q[i] == lk_set) begin
        lk_hit    = 1'b1;
        lk_target = lk_target | target_q[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: entry storage is explicitly cleared here, unlike a typical RAM, so no stale data survives reset.
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        set_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq_fire) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (coalesce) target_q[match_idx] <= enq_target;
      // Ordered after the dequeue clear: when full, tail == head and the new entry must win the slot.
      if (alloc) begin
        valid[tail]    <= 1'b1;
        tag_q[tail]    <= enq_tag;
        set_q[tail]    <= enq_set;
        target_q[tail] <= enq_target;
        tail           <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(deq_fire);
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: allocation, coalescing, full refusal, wrap, flush.
module tb_btb_update_queue;

  logic        clk = 1'b0;
  logic        reset, flush, enq_valid, enq_ready, deq_valid, deq_ready, lk_hit;
  logic [9:0]  enq_tag, deq_tag, lk_tag;
  logic [3:0]  enq_set, deq_set, lk_set;
  logic [15:0] enq_target, deq_target, lk_target;
  logic [2:0]  count;

  int tests = 0;
  int failed = 0;

  btb_update_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_tag(enq_tag), .enq_set(enq_set), .enq_target(enq_target),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_tag(deq_tag), .deq_set(deq_set), .deq_target(deq_target),
    .deq_ready(deq_ready),
    .lk_tag(lk_tag), .lk_set(lk_set), .lk_hit(lk_hit), .lk_target(lk_target),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [9:0] t, input logic [3:0] s, input logic [15:0] a);
    enq_valid  = v;
    enq_tag    = t;
    enq_set    = s;
    enq_target = a;
  endtask

  task automatic lookup(input logic [9:0] t, input logic [3:0] s);
    lk_tag = t;
    lk_set = s;
    #1;
  endtask

  task automatic push(input logic [9:0] t, input logic [3:0] s, input logic [15:0] a);
    set_enq(1'b1, t, s, a);
    tick();
    set_enq(1'b0, '0, '0, '0);
  endtask

  task automatic expect_head(input string tag, input logic [9:0] t, input logic [3:0] s, input logic [15:0] a);
    #1;
    check({tag, "_valid"},  32'(deq_valid),  32'h1);
    check({tag, "_tag"},    32'(deq_tag),    32'(t));
    check({tag, "_set"},    32'(deq_set),    32'(s));
    check({tag, "_target"}, 32'(deq_target), 32'(a));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, '0, '0, '0);
    lk_tag = 10'h12A; lk_set = 4'h3;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_count",      32'(count),      32'h0);
    check("rst_deq_valid",  32'(deq_valid),  32'h0);
    check("rst_deq_tag",    32'(deq_tag),    32'h0);
    check("rst_deq_set",    32'(deq_set),    32'h0);
    check("rst_deq_target", 32'(deq_target), 32'h0);
    check("rst_lk_hit",     32'(lk_hit),     32'h0);
    check("rst_lk_target",  32'(lk_target),  32'h0);
    check("rst_enq_ready",  32'(enq_ready),  32'h1);

    // First entry becomes visible after the write edge.
    push(10'h12A, 4'h3, 16'h4000);
    expect_head("first", 10'h12A, 4'h3, 16'h4000);
    check("first_count", 32'(count), 32'h1);
    lookup(10'h12A, 4'h3);
    check("first_lk_hit",    32'(lk_hit),    32'h1);
    check("first_lk_target", 32'(lk_target), 32'h4000);

    // Fill to four entries with the drain stalled.
    push(10'h001, 4'h1, 16'h1000);
    push(10'h002, 4'h2, 16'h2000);
    push(10'h003, 4'h3, 16'h3000);
    check("full_count", 32'(count), 32'h4);
    set_enq(1'b1, 10'h3FF, 4'h1, 16'h7000);
    #1;
    check("full_refuse_ready", 32'(enq_ready), 32'h0);
    tick();
    check("full_refuse_count", 32'(count), 32'h4);

    // Coalesce into the stalled head while full.
    set_enq(1'b1, 10'h12A, 4'h3, 16'h5000);
    #1;
    check("coal_ready", 32'(enq_ready), 32'h1);
    tick();
    set_enq(1'b0, '0, '0, '0);
    #1;
    check("coal_count",  32'(count),      32'h4);
    check("coal_head",   32'(deq_target), 32'h5000);
    lookup(10'h12A, 4'h3);
    check("coal_lk",     32'(lk_target),  32'h5000);

    // Full + dequeue + new tag: refused this cycle, accepted the next.
    set_enq(1'b1, 10'h3FF, 4'h1, 16'h7000);
    deq_ready = 1'b1;
    #1;
    check("fulldeq_ready", 32'(enq_ready), 32'h0);
    tick();
    deq_ready = 1'b0;
    #1;
    check("fulldeq_count", 32'(count), 32'h3);
    check("fulldeq_ready_after", 32'(enq_ready), 32'h1);
    tick();
    set_enq(1'b0, '0, '0, '0);
    #1;
    check("retry_count", 32'(count), 32'h4);
    lookup(10'h3FF, 4'h1);
    check("retry_lk_hit",    32'(lk_hit),    32'h1);
    check("retry_lk_target", 32'(lk_target), 32'h7000);

    // Drain all four in FIFO order.
    deq_ready = 1'b1;
    expect_head("drain0", 10'h001, 4'h1, 16'h1000); tick();
    expect_head("drain1", 10'h002, 4'h2, 16'h2000); tick();
    expect_head("drain2", 10'h003, 4'h3, 16'h3000); tick();
    expect_head("drain3", 10'h3FF, 4'h1, 16'h7000); tick();
    deq_ready = 1'b0;
    #1;
    check("drained_count",  32'(count),     32'h0);
    check("drained_valid",  32'(deq_valid), 32'h0);
    check("drained_tag",    32'(deq_tag),   32'h0);

    // Pointers wrap; order preserved.
    push(10'h0AA, 4'h5, 16'h0A00);
    push(10'h0BB, 4'h6, 16'h0B00);
    push(10'h0CC, 4'h7, 16'h0C00);
    check("wrap_count", 32'(count), 32'h3);
    deq_ready = 1'b1;
    expect_head("wrap0", 10'h0AA, 4'h5, 16'h0A00); tick();
    expect_head("wrap1", 10'h0BB, 4'h6, 16'h0B00); tick();
    expect_head("wrap2", 10'h0CC, 4'h7, 16'h0C00); tick();
    deq_ready = 1'b0;
    #1;
    check("wrap_empty", 32'(count), 32'h0);

    // Flush beats a simultaneous enqueue and dequeue.
    push(10'h0AA, 4'h5, 16'h0A00);
    push(10'h0BB, 4'h6, 16'h0B00);
    push(10'h0CC, 4'h7, 16'h0C00);
    set_enq(1'b1, 10'h0DD, 4'h8, 16'h0D00);
    deq_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, '0, '0, '0);
    #1;
    check("flush_count", 32'(count),     32'h0);
    check("flush_valid", 32'(deq_valid), 32'h0);
    lookup(10'h0DD, 4'h8);
    check("flush_lk_new", 32'(lk_hit), 32'h0);
    lookup(10'h0AA, 4'h5);
    check("flush_lk_old", 32'(lk_hit), 32'h0);

    // Re-enqueue the head while it dequeues: new entry at tail.
    push(10'h12A, 4'h3, 16'h4000);
    push(10'h055, 4'h2, 16'h0550);
    set_enq(1'b1, 10'h12A, 4'h3, 16'h6000);
    deq_ready = 1'b1;
    #1;
    check("hdq_ready",     32'(enq_ready),  32'h1);
    check("hdq_old_head",  32'(deq_target), 32'h4000);
    tick();
    set_enq(1'b0, '0, '0, '0);
    deq_ready = 1'b0;
    #1;
    check("hdq_count", 32'(count), 32'h2);
    expect_head("hdq_next", 10'h055, 4'h2, 16'h0550);
    lookup(10'h12A, 4'h3);
    check("hdq_lk_hit",    32'(lk_hit),    32'h1);
    check("hdq_lk_target", 32'(lk_target), 32'h6000);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    expect_head("hdq_tail", 10'h12A, 4'h3, 16'h6000);
    check("hdq_final_count", 32'(count), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
